// File: rtl/top_function_core.sv
// top_function_core
//   Accelerator core that evaluates f1(n) = sum(i) and f2(n) = sum(i*i) for
//   i = 0..n-1, one iteration per clock and one series after the other.
//   It returns f1 + f2 modulo 2^DATA_WIDTH.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   start      : call request, sampled only while ready is high
//   ready      : high while idle and able to accept start
//   finish     : one-cycle pulse; return_val is valid in that cycle
//   return_val : result of the most recently completed call
//   n          : signed argument, captured when start is accepted
module top_function_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  output logic                  finish,
  output logic [DATA_WIDTH-1:0] return_val,
  input  logic [DATA_WIDTH-1:0] n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] n_reg;
  logic [DATA_WIDTH-1:0] i_q;
  logic [DATA_WIDTH-1:0] acc1_q;
  logic [DATA_WIDTH-1:0] acc2_q;
  logic [DATA_WIDTH-1:0] acc2_next;
  logic [DATA_WIDTH-1:0] sq;
  logic                  n_pos;
  logic                  last_iter;

  // Signed n > 0 without a signed compare: sign bit clear and non-zero.
  assign n_pos     = !n[DATA_WIDTH-1] && (n != '0);
  assign last_iter = (i_q == (n_reg - DATA_WIDTH'(1)));
  assign sq        = i_q * i_q;
  assign acc2_next = acc2_q + sq;

  assign ready  = (state_q == S_IDLE);
  assign finish = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = n_pos ? S_F1 : S_DONE;
        end
      end
      S_F1: begin
        if (last_iter) begin
          state_d = S_F2;
        end
      end
      S_F2: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg      <= '0;
      i_q        <= '0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      return_val <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_reg  <= n;
            i_q    <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
            if (!n_pos) begin
              return_val <= '0;
            end
          end
        end
        S_F1: begin
          acc1_q <= acc1_q + i_q;
          if (last_iter) begin
            i_q <= '0;
          end else begin
            i_q <= i_q + DATA_WIDTH'(1);
          end
        end
        S_F2: begin
          acc2_q <= acc2_next;
          i_q    <= i_q + DATA_WIDTH'(1);
          if (last_iter) begin
            // Uses acc2_next so the final square is included in this cycle.
            return_val <= acc1_q + acc2_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_function_core.sv
module tb_top_function_core;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ready;
  logic        finish;
  logic [31:0] return_val;
  logic [31:0] n;

  int unsigned total;
  int unsigned bad;

  top_function_core #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ready      (ready),
    .finish     (finish),
    .return_val (return_val),
    .n          (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One call from IDLE; edges counted with the start-sampling edge as 1.
  // With disturb set, start is pulsed and n changed to 99 mid-call.
  task automatic run_call(input string tag, input logic [31:0] nv,
                          input logic [31:0] exp_val, input int unsigned exp_lat,
                          input bit disturb);
    int unsigned edges;
    chk({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
    n     = nv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    chk({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
    while (finish !== 1'b1 && edges < 7000) begin
      if (disturb && edges == 3) begin
        start = 1'b1;
        n     = 32'd99;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    chk({tag, "_finish"}, {31'd0, finish}, 32'd1);
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_return_val"}, return_val, exp_val);
    @(posedge clk);
    #1;
    chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    chk({tag, "_finish_pulse"}, {31'd0, finish}, 32'd0);
    chk({tag, "_hold"}, return_val, exp_val);
  endtask

  initial begin
    int unsigned nfin;
    int unsigned fin_pos[3];

    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    n     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_return_val", return_val, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready_after", {31'd0, ready}, 32'd1);

    // Basic and boundary calls
    run_call("n5",   32'd5,           32'd40,        11,   1'b0);
    run_call("n0",   32'd0,           32'd0,         1,    1'b0);
    run_call("n10a", 32'd10,          32'd330,       21,   1'b0);
    run_call("nneg", 32'hFFFF_FFFD,   32'd0,         1,    1'b0);
    run_call("n1",   32'd1,           32'd0,         3,    1'b0);

    // Mid-call start pulse and n change are ignored
    run_call("n10d", 32'd10,          32'd330,       21,   1'b1);
    nfin = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) nfin++;
    end
    chk("ignored_start_no_call", nfin, 32'd0);
    chk("ignored_start_ready", {31'd0, ready}, 32'd1);

    // Wrap-around
    run_call("n3000", 32'd3000,       32'd410064408, 6001, 1'b0);

    // start held high: back-to-back calls every 6 cycles
    n     = 32'd2;
    start = 1'b1;
    nfin  = 0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) begin
        if (nfin < 3) fin_pos[nfin] = k;
        nfin++;
        chk("held_return_val", return_val, 32'd2);
      end
    end
    start = 1'b0;
    chk("held_count", nfin, 32'd3);
    chk("held_first", fin_pos[0], 32'd5);
    chk("held_second", fin_pos[1], 32'd11);
    chk("held_third", fin_pos[2], 32'd17);
    @(posedge clk);
    #1;
    chk("held_idle", {31'd0, ready}, 32'd1);

    // Reset during F2 of an n=10 call
    n     = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_finish", {31'd0, finish}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_return_val", return_val, 32'd0);
    nfin = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) nfin++;
    end
    chk("abort_no_finish", nfin, 32'd0);
    run_call("n5b", 32'd5, 32'd40, 11, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
